// File: rtl/pixel_pkg.sv
// pixel_pkg: shared mode encodings, bar colours and default 800x600 timing
package pixel_pkg;
    typedef enum logic [1:0] {
        MODE_IMG   = 2'd0,
        MODE_BARS  = 2'd1,
        MODE_CHK   = 2'd2,
        MODE_SOLID = 2'd3
    } mode_t;
    // {R,G,B} all-ones flags per bar
    localparam logic [2:0] BAR_WHITE   = 3'b111;
    localparam logic [2:0] BAR_YELLOW  = 3'b110;
    localparam logic [2:0] BAR_CYAN    = 3'b011;
    localparam logic [2:0] BAR_GREEN   = 3'b010;
    localparam logic [2:0] BAR_MAGENTA = 3'b101;
    localparam logic [2:0] BAR_RED     = 3'b100;
    localparam logic [2:0] BAR_BLUE    = 3'b001;
    localparam logic [2:0] BAR_BLACK   = 3'b000;
    // index 0 is the leftmost bar
    localparam logic [7:0][2:0] BAR_COLORS = {BAR_BLACK, BAR_BLUE, BAR_RED, BAR_MAGENTA,
                                              BAR_GREEN, BAR_CYAN, BAR_YELLOW, BAR_WHITE};
    localparam int H_ACTIVE_DEF = 800;
    localparam int H_TOTAL_DEF  = 1056;
    localparam int V_ACTIVE_DEF = 600;
    localparam int V_TOTAL_DEF  = 628;
endpackage

// File: rtl/pixel_if.sv
// pixel_if: image ROM read bus
//   mem_addr  master->slave  ROM read address
//   mem_data  slave->master  {R,G,B} word for the address of the previous cycle
interface pixel_if #(
    parameter int ADDR_W  = 17,
    parameter int COLOR_W = 8
);
    logic [ADDR_W-1:0]    mem_addr;
    logic [3*COLOR_W-1:0] mem_data;
    modport master (output mem_addr, input mem_data);
    modport slave  (input mem_addr, output mem_data);
endinterface

// File: rtl/pattern_gen.sv
// pattern_gen: combinational bars / checker / solid colour from the counters
//   i_hcnt, i_vcnt  raw h/v counters
//   i_frame         frame counter, scrolls the bars
//   i_mode          source select; image mode yields the solid colour (border)
//   i_solid         {R,G,B} solid colour
//   o_rgb           {R,G,B} pattern colour
module pattern_gen
    import pixel_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int COLOR_W  = 8,
    parameter int CHK_LOG2 = 5
) (
    input  logic [10:0]          i_hcnt,
    input  logic [9:0]           i_vcnt,
    input  logic [7:0]           i_frame,
    input  mode_t                i_mode,
    input  logic [3*COLOR_W-1:0] i_solid,
    output logic [3*COLOR_W-1:0] o_rgb
);
    localparam int BAR_W = H_ACTIVE / 8;
    logic [11:0] w_pos;
    logic [2:0]  w_bar;
    logic        w_chk;
    logic [2:0]  w_bits;
    assign w_pos  = 12'(i_hcnt) + 12'(i_frame);
    // truncation to 3 bits gives the mod-8 wrap of the bar index
    assign w_bar  = 3'(w_pos / 12'(BAR_W));
    assign w_chk  = 1'(({1'b0, i_vcnt} ^ i_hcnt) >> CHK_LOG2);
    assign w_bits = i_mode == MODE_BARS ? BAR_COLORS[w_bar] : {3{w_chk}};
    assign o_rgb  = (i_mode == MODE_BARS || i_mode == MODE_CHK)
                  ? {{COLOR_W{w_bits[2]}}, {COLOR_W{w_bits[1]}}, {COLOR_W{w_bits[0]}}}
                  : i_solid;
endmodule

// File: rtl/pixel_source.sv
// pixel_source: counters -> one RGB pixel per clock, fixed 2-cycle latency
//   clk, rst_n          pixel clock, asynchronous active-low reset
//   i_count_rgb         horizontal counter
//   i_reset_count_rgb   vertical counter
//   i_mode_req          requested source, latched at (0,0)
//   i_solid_rgb         {R,G,B} for solid mode and the image border
//   rom                 image ROM bus (registered address, data one cycle later)
//   o_red/green/blue    pixel colour
//   o_de                visible-pixel flag aligned with the colour
module pixel_source
    import pixel_pkg::*;
#(
    parameter int H_ACTIVE   = H_ACTIVE_DEF,
    parameter int V_ACTIVE   = V_ACTIVE_DEF,
    parameter int IMG_W      = 400,
    parameter int IMG_H      = 300,
    parameter int SCALE_LOG2 = 1,
    parameter int X0         = 0,
    parameter int Y0         = 0,
    parameter int COLOR_W    = 8,
    parameter int ADDR_W     = 17,
    parameter int CHK_LOG2   = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [10:0]          i_count_rgb,
    input  logic [9:0]           i_reset_count_rgb,
    input  logic [1:0]           i_mode_req,
    input  logic [3*COLOR_W-1:0] i_solid_rgb,
    pixel_if.master              rom,
    output logic [COLOR_W-1:0]   o_red,
    output logic [COLOR_W-1:0]   o_green,
    output logic [COLOR_W-1:0]   o_blue,
    output logic                 o_de
);
    localparam int IMG_SW = IMG_W << SCALE_LOG2;
    localparam int IMG_SH = IMG_H << SCALE_LOG2;
    int                   w_x;
    int                   w_y;
    logic                 w_sof;
    logic                 w_vis;
    logic                 w_in_img;
    mode_t                w_mode;
    logic [7:0]           w_frame;
    logic [ADDR_W-1:0]    w_addr;
    logic [3*COLOR_W-1:0] w_pat;
    mode_t                r_mode;
    logic [7:0]           r_frame;
    logic                 r_run;
    logic [ADDR_W-1:0]    r_addr;
    logic                 r_vis;
    logic                 r_img_sel;
    logic [3*COLOR_W-1:0] r_pat;
    logic                 r_de;
    logic [3*COLOR_W-1:0] r_rgb;
    assign w_sof   = i_count_rgb == 11'd0 && i_reset_count_rgb == 10'd0;
    // the (0,0) pixel itself already uses the newly latched mode
    assign w_mode  = w_sof ? mode_t'(i_mode_req) : r_mode;
    // the first frame after reset is frame 0; later frame starts advance it
    assign w_frame = (w_sof && r_run) ? r_frame + 8'd1 : r_frame;
    // nothing is visible between reset release and the first frame start
    assign w_vis   = (r_run || w_sof) && i_count_rgb < 11'(H_ACTIVE)
                   && i_reset_count_rgb < 10'(V_ACTIVE);
    assign w_x      = int'(i_count_rgb) - X0;
    assign w_y      = int'(i_reset_count_rgb) - Y0;
    assign w_in_img = w_vis && w_x >= 0 && w_x < IMG_SW && w_y >= 0 && w_y < IMG_SH;
    assign w_addr   = ADDR_W'((w_y >> SCALE_LOG2) * IMG_W + (w_x >> SCALE_LOG2));
    pattern_gen #(
        .H_ACTIVE(H_ACTIVE),
        .COLOR_W (COLOR_W),
        .CHK_LOG2(CHK_LOG2)
    ) u_pat (
        .i_hcnt (i_count_rgb),
        .i_vcnt (i_reset_count_rgb),
        .i_frame(w_frame),
        .i_mode (w_mode),
        .i_solid(i_solid_rgb),
        .o_rgb  (w_pat)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode    <= MODE_IMG;
            r_frame   <= '0;
            r_run     <= 1'b0;
            r_addr    <= '0;
            r_vis     <= 1'b0;
            r_img_sel <= 1'b0;
            r_pat     <= '0;
            r_de      <= 1'b0;
            r_rgb     <= '0;
        end else begin
            r_mode    <= w_mode;
            r_frame   <= w_frame;
            r_run     <= r_run | w_sof;
            // holding the address outside the image keeps it within the ROM
            if (w_in_img) r_addr <= w_addr;
            r_vis     <= w_vis;
            r_img_sel <= w_in_img && w_mode == MODE_IMG;
            r_pat     <= w_pat;
            r_de      <= r_vis;
            r_rgb     <= r_vis ? (r_img_sel ? rom.mem_data : r_pat) : '0;
        end
    end
    assign rom.mem_addr = r_addr;
    assign {o_red, o_green, o_blue} = r_rgb;
    assign o_de = r_de;
endmodule

// File: tb/tb_pixel_source.sv
// tb_pixel_source: scoreboard bench for two pixel_source placements
module tb_pixel_source;
    typedef struct {
        logic [24:0] a;
        logic [24:0] b;
    } exp_t;
    localparam logic [23:0] BAR_RGB [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                           24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    logic        clk = 1'b0;
    logic        rst_n;
    logic [10:0] hc;
    logic [9:0]  vc;
    logic [1:0]  mreq;
    logic [23:0] solid;
    logic [7:0]  ra, ga, ba, rb, gb, bb;
    logic        dea, deb;
    int          n_chk = 0;
    int          n_fail = 0;
    int          m_mode = 0;
    int          m_frame = 0;
    bit          m_run = 0;
    bit          counting = 0;
    int          de_cnt = 0;
    exp_t        sb[$];

    always #5 clk = ~clk;

    pixel_if #(.ADDR_W(17), .COLOR_W(8)) rom_a ();
    pixel_if #(.ADDR_W(17), .COLOR_W(8)) rom_b ();
    assign rom_a.mem_data = 24'(rom_a.mem_addr);
    assign rom_b.mem_data = 24'(rom_b.mem_addr);

    pixel_source u_a (
        .clk(clk), .rst_n(rst_n), .i_count_rgb(hc), .i_reset_count_rgb(vc),
        .i_mode_req(mreq), .i_solid_rgb(solid), .rom(rom_a),
        .o_red(ra), .o_green(ga), .o_blue(ba), .o_de(dea)
    );
    pixel_source #(.SCALE_LOG2(0), .X0(100), .Y0(50)) u_b (
        .clk(clk), .rst_n(rst_n), .i_count_rgb(hc), .i_reset_count_rgb(vc),
        .i_mode_req(mreq), .i_solid_rgb(solid), .rom(rom_b),
        .o_red(rb), .o_green(gb), .o_blue(bb), .o_de(deb)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [24:0] model(input int h, input int v, input int md, input int fr,
                                          input bit run, input int x0, input int y0,
                                          input int sc, input logic [23:0] sol);
        int x, y;
        if (!run || h >= 800 || v >= 600) return 25'd0;
        x = h - x0;
        y = v - y0;
        case (md)
            0: return {1'b1, (x >= 0 && x < (400 << sc) && y >= 0 && y < (300 << sc))
                             ? 24'((y >> sc) * 400 + (x >> sc)) : sol};
            1: return {1'b1, BAR_RGB[((h + fr) / 100) % 8]};
            2: return {1'b1, (((h >> 5) ^ (v >> 5)) & 1) != 0 ? 24'hFFFFFF : 24'h000000};
            default: return {1'b1, sol};
        endcase
    endfunction

    task automatic step(input int h, input int v);
        exp_t e;
        @(negedge clk);
        if (sb.size() >= 2) begin
            e = sb.pop_front();
            check("de_a", 32'(dea), 32'(e.a[24]));
            check("rgb_a", 32'({ra, ga, ba}), 32'(e.a[23:0]));
            check("de_b", 32'(deb), 32'(e.b[24]));
            check("rgb_b", 32'({rb, gb, bb}), 32'(e.b[23:0]));
            check("addr_rng", 32'(rom_a.mem_addr <= 17'd119999), 32'd1);
        end
        if (counting && dea) de_cnt++;
        hc = 11'(h);
        vc = 10'(v);
        if (h == 0 && v == 0) begin
            if (m_run) m_frame = (m_frame + 1) % 256;
            m_mode = int'(mreq);
            m_run = 1;
        end
        e.a = model(h, v, m_mode, m_frame, m_run, 0, 0, 1, solid);
        e.b = model(h, v, m_mode, m_frame, m_run, 100, 50, 0, solid);
        sb.push_back(e);
    endtask

    initial begin
        rst_n = 1'b0;
        hc = 11'd500;
        vc = 10'd10;
        mreq = 2'd1;
        solid = 24'hA5C3E1;
        repeat (10) @(negedge clk);
        check("rst_de", 32'(dea), 32'd0);
        check("rst_rgb", 32'({ra, ga, ba}), 32'd0);
        check("rst_addr", 32'(rom_a.mem_addr), 32'd0);
        check("rst_de_b", 32'(deb), 32'd0);
        rst_n = 1'b1;
        for (int i = 501; i < 510; i++) step(i, 10);
        step(0, 0);
        step(99, 0);
        step(100, 0);
        step(799, 0);
        step(800, 0);
        step(0, 0);
        step(99, 0);
        step(199, 0);
        repeat (255) step(0, 0);
        step(99, 0);
        step(0, 1);
        mreq = 2'd0;
        step(0, 0);
        step(1, 0);
        step(0, 1);
        step(1, 1);
        step(2, 0);
        step(799, 599);
        @(posedge clk);
        #1 check("addr_last", 32'(rom_a.mem_addr), 32'd119999);
        step(99, 50);
        step(100, 50);
        step(101, 50);
        step(100, 51);
        step(499, 349);
        @(posedge clk);
        #1 check("addr_last_b", 32'(rom_b.mem_addr), 32'd119999);
        step(500, 349);
        step(100, 350);
        step(1040, 50);
        step(799, 600);
        repeat (150) step(int'($urandom_range(1, 1100)), int'($urandom_range(0, 650)));
        step(10, 299);
        mreq = 2'd2;
        step(10, 300);
        step(40, 300);
        step(0, 0);
        step(32, 0);
        step(32, 32);
        repeat (50) step(int'($urandom_range(1, 1100)), int'($urandom_range(1, 650)));
        solid = 24'h123456;
        mreq = 2'd3;
        step(0, 0);
        step(1050, 4);
        step(1051, 4);
        counting = 1;
        for (int h = 0; h < 1056; h++) step(h, 5);
        step(1050, 5);
        step(1051, 5);
        counting = 0;
        check("de_per_line", 32'(de_cnt), 32'd800);
        step(10, 5);
        step(11, 5);
        step(12, 5);
        #3 rst_n = 1'b0;
        #1;
        check("async_de", 32'(dea), 32'd0);
        check("async_rgb", 32'({ra, ga, ba}), 32'd0);
        check("async_addr", 32'(rom_a.mem_addr), 32'd0);
        check("async_de_b", 32'(deb), 32'd0);
        sb.delete();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
